// File: rtl/port_out_write_arbiter_pkg.sv
// Shared definitions for the output-port bank write arbiter.
//   PORT_BASE_ADDR : first address of the 16-entry output-port window
//   PORT_COUNT     : number of ports in the window
//   state_e        : arbiter FSM states
//   in_window()    : true when an address falls inside the port window
package port_out_write_arbiter_pkg;

  localparam logic [7:0] PORT_BASE_ADDR = 8'hE0;
  localparam int         PORT_COUNT     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // The window is 16-aligned, so a high-nibble match is an exact range check.
  function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
    return addr[7:4] == base[7:4];
  endfunction

endpackage

// File: rtl/port_out_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index of the highest-priority requester
//   win_o : one-hot winner (zero when no request)
module rr_priority_picker #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o
);

  logic found;
  int   idx;

  // Scan from the pointer upward, wrapping, and take the first request.
  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_out_write_arbiter.sv
// Round-robin arbiter sharing the output-port bank write bus between N_REQ masters.
//   clk, reset          : clock, asynchronous active-high reset
//   req_i / lock_i      : per-master request and burst lock
//   addr_i / data_i     : per-master address and data, master i at [8i+7:8i]
//   ack_o / err_o       : one-cycle completion / out-of-window pulses to the owner
//   grant_o             : one-hot current owner, zero when the bus is free
//   port_address/_data/_write : registered drive of the port bank write inputs
module port_out_write_arbiter
  import port_out_write_arbiter_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter logic [7:0] BASE_ADDR    = PORT_BASE_ADDR,
  parameter int         LOCK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   lock_i,
  input  logic [8*N_REQ-1:0] addr_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   err_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         port_address,
  output logic [7:0]         port_data,
  output logic               port_write
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   own_q, own_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic               wr_q, wr_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   win;
  logic [PTR_W-1:0]   win_idx;
  logic               load;
  logic [PTR_W-1:0]   load_idx;
  logic [7:0]         ld_addr, ld_data;
  logic               ld_ok;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    grant_d  = grant_q;
    ack_d    = '0;
    err_d    = '0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    load_idx = own_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          load     = 1'b1;
          load_idx = win_idx;
        end
      end
      ST_ISSUE: begin
        ptr_d = (own_q == PTR_W'(N_REQ - 1)) ? '0 : own_q + 1'b1;
        cnt_d = '0;
        if (lock_i[own_q]) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_HOLD: begin
        // Dropping lock releases even if the owner also raised req.
        if (!lock_i[own_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (req_i[own_q]) begin
          load     = 1'b1;
          load_idx = own_q;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    ld_addr = '0;
    ld_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == load_idx) begin
        ld_addr = addr_i[8*i +: 8];
        ld_data = data_i[8*i +: 8];
      end
    end
    ld_ok = in_window(ld_addr, BASE_ADDR);

    // Outputs for the ISSUE cycle are prepared here so they appear registered.
    if (load) begin
      state_d           = ST_ISSUE;
      own_d             = load_idx;
      grant_d           = '0;
      grant_d[load_idx] = 1'b1;
      ack_d[load_idx]   = 1'b1;
      err_d[load_idx]   = !ld_ok;
      wr_d              = ld_ok;
      addr_d            = ld_addr;
      data_d            = ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign grant_o      = grant_q;
  assign port_address = addr_q;
  assign port_data    = data_q;
  assign port_write   = wr_q;

endmodule
